// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two valid/ready
// requesters. Round-robin grant, one-entry response register tagged with
// the requester ID, operand isolation when idle, and an idle power hint.
module alu_share_arbiter #(
  parameter int WIDTH       = 32,
  parameter int OPW         = 6,
  parameter int IDLE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  // Port 0: integer pipe
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  // Port 1: address/branch helper
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  // Shared ALU
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_operand_a,
  output logic [WIDTH-1:0] alu_operand_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             alu_en,
  // Response
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  // Power hint
  output logic             alu_idle
);

  localparam int            CW       = $clog2(IDLE_CYCLES + 1);
  localparam logic [CW-1:0] IDLE_MAX = CW'(IDLE_CYCLES);

  // rr_ptr names the port that wins when both request; it moves to the
  // other port after every accepted request.
  logic             rr_ptr;
  logic             grant;
  logic             can_accept;
  logic             accept;
  logic [OPW-1:0]   held_op;
  logic [WIDTH-1:0] held_a;
  logic [WIDTH-1:0] held_b;
  logic [CW-1:0]    idle_cnt;
  logic             idle_q;

  // The response slot can take a new result if empty or draining this cycle.
  assign can_accept = ~rsp_valid | rsp_ready;
  assign accept     = can_accept & (req0_valid | req1_valid);
  assign alu_en     = accept;

  // Ready can only rise for the granted port, and only when it is valid.
  assign req0_ready = accept & ~grant;
  assign req1_ready = accept &  grant;

  // The hint drops combinationally as soon as work arrives.
  assign alu_idle = idle_q & ~accept;

  // Round-robin grant: a lone requester wins, a tie goes to rr_ptr.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = rr_ptr;
    else if (req1_valid)          grant = 1'b1;
  end

  // Operand isolation: only the accepted request reaches the ALU; otherwise
  // the last accepted operands are replayed so the ALU inputs do not toggle.
  always_comb begin
    alu_op        = held_op;
    alu_operand_a = held_a;
    alu_operand_b = held_b;
    if (accept) begin
      alu_op        = grant ? req1_op : req0_op;
      alu_operand_a = grant ? req1_a  : req0_a;
      alu_operand_b = grant ? req1_b  : req0_b;
    end
  end

  // Response slot, held operands and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      held_op   <= '0;
      held_a    <= '0;
      held_b    <= '0;
      rr_ptr    <= 1'b0;
    end else if (accept) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      rsp_valid <= 1'b1;
      rsp_id    <= grant;
      rsp_data  <= alu_result;
      held_op   <= alu_op;
      held_a    <= alu_operand_a;
      held_b    <= alu_operand_b;
      rr_ptr    <= ~grant;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Idle counter saturating at IDLE_CYCLES, and the registered idle hint.
  // The hint is only set on a cycle without an accept, so it never lingers
  // into the cycle after new work arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      idle_q   <= 1'b0;
    end else begin
      idle_q <= ~accept & (idle_cnt == IDLE_MAX) & ~rsp_valid;
      if (accept)                   idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed + random stimulus against a cycle-level
// reference model; responses are checked by a scoreboard queue drained by
// an independent monitor process.
module tb_alu_share_arbiter;

  localparam int W    = 32;
  localparam int OPW  = 6;
  localparam int IDLE = 8;

  localparam logic [OPW-1:0] OP_ADD = 6'b000010;
  localparam logic [OPW-1:0] OP_SUB = 6'b000110;
  localparam logic [OPW-1:0] OP_AND = 6'b000111;
  localparam logic [OPW-1:0] OP_OR  = 6'b000101;
  localparam logic [OPW-1:0] OP_SLL = 6'b000100;
  localparam logic [OPW-1:0] OP_SRL = 6'b000011;

  typedef struct {
    logic         id;
    logic [W-1:0] data;
  } rsp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req0_valid = 1'b0, req1_valid = 1'b0;
  logic           req0_ready, req1_ready;
  logic [OPW-1:0] req0_op = '0, req1_op = '0;
  logic [W-1:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [OPW-1:0] alu_op;
  logic [W-1:0]   alu_operand_a, alu_operand_b, alu_result;
  logic           alu_en;
  logic           rsp_valid, rsp_id;
  logic           rsp_ready = 1'b0;
  logic [W-1:0]   rsp_data;
  logic           alu_idle;

  int errors = 0;
  int checks = 0;
  rsp_t sb[$];

  // Reference model state
  int           m_prio;      // port favoured on a tie
  bit           m_rsp_valid;
  int           m_idle_cnt;
  bit           m_idle_q;
  logic [OPW-1:0] m_op;
  logic [W-1:0]   m_a, m_b;

  alu_share_arbiter #(.WIDTH(W), .OPW(OPW), .IDLE_CYCLES(IDLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_operand_a(alu_operand_a),
    .alu_operand_b(alu_operand_b), .alu_result(alu_result), .alu_en(alu_en),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .alu_idle(alu_idle)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_f(logic [OPW-1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      default: return '0;
    endcase
  endfunction

  // Behavioural ALU standing in for the shared datapath
  always_comb alu_result = alu_f(alu_op, alu_operand_a, alu_operand_b);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prio = 0; m_rsp_valid = 0; m_idle_cnt = 0; m_idle_q = 0;
    m_op = '0; m_a = '0; m_b = '0;
    sb.delete();
  endtask

  // One clock cycle: drive at the negedge, check combinational outputs,
  // advance the model as of the coming posedge, wait for the next negedge.
  task automatic cycle(input bit v0, input logic [OPW-1:0] op0, input logic [W-1:0] a0,
                       input logic [W-1:0] b0, input bit v1, input logic [OPW-1:0] op1,
                       input logic [W-1:0] a1, input logic [W-1:0] b1, input bit rr);
    bit acc, can_acc;
    int g;
    logic [OPW-1:0] gop;
    logic [W-1:0]   ga, gb;
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    rsp_ready  = rr;
    #1;
    g       = (v0 && v1) ? m_prio : (v1 ? 1 : 0);
    can_acc = !m_rsp_valid || rr;
    acc     = can_acc && (v0 || v1);
    gop = g ? op1 : op0;
    ga  = g ? a1  : a0;
    gb  = g ? b1  : b0;
    check("rsp_valid", rsp_valid, m_rsp_valid);
    check("req0_ready", req0_ready, acc && g == 0);
    check("req1_ready", req1_ready, acc && g == 1);
    check("alu_en", alu_en, acc);
    check("alu_idle", alu_idle, m_idle_q && !acc);
    check("alu_op", alu_op, acc ? gop : m_op);
    check("alu_a", alu_operand_a, acc ? ga : m_a);
    check("alu_b", alu_operand_b, acc ? gb : m_b);
    // Model update for the posedge
    m_idle_q = !acc && (m_idle_cnt == IDLE) && !m_rsp_valid;
    if (acc) begin
      sb.push_back('{id: logic'(g), data: alu_f(gop, ga, gb)});
      m_op = gop; m_a = ga; m_b = gb;
      m_prio = 1 - g;
      m_rsp_valid = 1;
      m_idle_cnt = 0;
    end else begin
      if (rr) m_rsp_valid = 0;
      if (m_idle_cnt < IDLE) m_idle_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic idle_cycle(input bit rr);
    cycle(0, '0, '0, '0, 0, '0, '0, '0, rr);
  endtask

  // Monitor: compares every presented response with the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 1'b1, 1'b0);
        end else begin
          check("rsp_id", rsp_id, sb[0].id);
          check("rsp_data", rsp_data, sb[0].data);
          if (rsp_ready) void'(sb.pop_front());
        end
      end
    end
  end

  logic [OPW-1:0] ops [6];

  initial begin
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SRL};
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // Reset state
    #1;
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id", rsp_id, 1'b0);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_alu_idle", alu_idle, 1'b0);

    // Idle hint: 8 idle cycles, flag rises the cycle after the limit
    for (int i = 0; i < IDLE + 2; i++) idle_cycle(1);
    check("idle_hint_up", alu_idle, 1'b1);
    // SRL 0x20 >> 5 drops it
    cycle(1, OP_SRL, 32'h20, 32'd5, 0, '0, '0, '0, 1);
    check("srl_data", rsp_data, 32'h1);

    // Single request ADD 100+50
    cycle(1, OP_ADD, 32'd100, 32'd50, 0, '0, '0, '0, 1);
    check("add_data", rsp_data, 32'd150);
    check("add_id", rsp_id, 1'b0);
    idle_cycle(1);

    // Contention: last grant was port 0, so port 1 leads here
    for (int i = 0; i < 4; i++)
      cycle(1, OP_SUB, 32'd0, 32'd1, 1, OP_OR, 32'hFFFF0000, 32'h0000FFFF, 1);
    idle_cycle(1);

    // Backpressure: SLL 1<<5 then 3 stalled cycles with port 0 pending
    cycle(0, '0, '0, '0, 1, OP_SLL, 32'd1, 32'd5, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, OP_ADD, 32'd7, 32'd8, 0, '0, '0, '0, 0);
      check("bp_data_hold", rsp_data, 32'h20);
    end
    cycle(1, OP_ADD, 32'd7, 32'd8, 0, '0, '0, '0, 1);
    idle_cycle(1);

    // Isolation: AND, then 5 idle cycles with random data on the buses
    cycle(1, OP_AND, 32'hFFFF0000, 32'h0000FFFF, 0, '0, '0, '0, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(0, OPW'($urandom), $urandom, $urandom, 0, OPW'($urandom), $urandom, $urandom, 1);
      check("iso_a", alu_operand_a, 32'hFFFF0000);
      check("iso_b", alu_operand_b, 32'h0000FFFF);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 2) != 0, ops[$urandom_range(0, 5)], $urandom, $urandom,
            $urandom_range(0, 2) != 0, ops[$urandom_range(0, 5)], $urandom, $urandom,
            $urandom_range(0, 3) != 0);
    end

    // Async reset while a response is pending
    cycle(1, OP_ADD, 32'd1, 32'd2, 0, '0, '0, '0, 0);
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check("mid_rst_alu_idle", alu_idle, 1'b0);
    check("mid_rst_ready0", req0_ready, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle(0);
    // First contended grant after reset goes to port 0
    cycle(1, OP_ADD, 32'd3, 32'd4, 1, OP_SUB, 32'd9, 32'd4, 1);
    check("post_rst_id", rsp_id, 1'b0);
    check("post_rst_data", rsp_data, 32'd7);
    cycle(1, OP_ADD, 32'd3, 32'd4, 1, OP_SUB, 32'd9, 32'd4, 1);
    check("post_rst_id2", rsp_id, 1'b1);
    for (int i = 0; i < 3; i++) idle_cycle(1);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
